// File: rtl/ariane_pkg.sv
// Minimal stand-in for the accelerator interface types of ariane_pkg.
// Only the fields the dispatcher path carries are modelled; layouts are opaque to the arbiter.
package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned XLEN          = 64;

    typedef struct packed {
        logic [31:0]              insn;
        logic [XLEN-1:0]          rs1;
        logic [XLEN-1:0]          rs2;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } accelerator_req_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
        logic                     error;
    } accelerator_resp_t;

endpackage

// File: rtl/fifo_v3.sv
// Port-compatible fifo_v3 (common_cells): circular buffer with optional fall-through,
// where a push into an empty FIFO is visible on data_o in the same cycle.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    dtype                  mem_q [FifoDepth];
    dtype                  mem_d [FifoDepth];
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(FifoDepth));
    assign empty_o = (cnt_q == '0) & ~(FALL_THROUGH & push_i);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        data_o   = mem_q[rd_ptr_q];

        if (push_i && !full_o) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = (rd_ptr_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
            cnt_d    = cnt_d - 1'b1;
        end
        // Fall-through: an entry pushed and popped while empty never occupies storage.
        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                cnt_d    = cnt_q;
                rd_ptr_d = rd_ptr_q;
                wr_ptr_d = wr_ptr_q;
            end
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/acc_port_arbiter.sv
// Shares one accelerator between NrPorts dispatcher ports: round-robin request grant with
// lock-on-stall, and in-order response routing through a queue of granted port indices.
module acc_port_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned NrPorts        = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  accelerator_req_t  [NrPorts-1:0]       req_i,
    input  logic              [NrPorts-1:0]       req_valid_i,
    output logic              [NrPorts-1:0]       req_ready_o,
    output accelerator_resp_t [NrPorts-1:0]       resp_o,
    output logic              [NrPorts-1:0]       resp_valid_o,
    input  logic              [NrPorts-1:0]       resp_ready_i,
    output accelerator_req_t                      acc_req_o,
    output logic                                  acc_req_valid_o,
    input  logic                                  acc_req_ready_i,
    input  accelerator_resp_t                     acc_resp_i,
    input  logic                                  acc_resp_valid_i,
    output logic                                  acc_resp_ready_o,
    output logic [$clog2(MaxOutstanding):0]       outstanding_o
);

    localparam int unsigned IdxW = $clog2(NrPorts);
    localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic [IdxW-1:0] rr_q, rr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [CntW-1:0] count_q, count_d;

    logic [IdxW-1:0] arb_idx, cand, grant_idx, head_idx;
    logic            found, not_full, push, pop;
    logic            fifo_empty, fifo_full;
    logic [CntW-2:0] fifo_usage;
    logic            unused_fifo_status;

    assign unused_fifo_status = ^{fifo_full, fifo_usage};

    // First valid port at or after rr_q, wrapping around.
    always_comb begin
        arb_idx = rr_q;
        cand    = rr_q;
        found   = 1'b0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            cand = IdxW'((32'(rr_q) + i) % NrPorts);
            if (!found && req_valid_i[cand]) begin
                found   = 1'b1;
                arb_idx = cand;
            end
        end
    end

    // Handshakes: a transfer happens in a cycle where valid and ready are both 1; valid
    // never depends on ready, and all valid/ready outputs are forced low while in reset.
    always_comb begin
        not_full        = (count_q < CntMax);
        grant_idx       = lock_q ? lock_idx_q : arb_idx;
        acc_req_valid_o = rst_ni && (|req_valid_i) && not_full;
        acc_req_o       = req_i[grant_idx];
        push            = acc_req_valid_o && acc_req_ready_i;
        req_ready_o     = '0;
        if (push) begin
            req_ready_o[grant_idx] = 1'b1;
        end

        lock_d     = acc_req_valid_o && !acc_req_ready_i;
        lock_idx_d = grant_idx;
        rr_d       = push ? IdxW'((32'(grant_idx) + 1) % NrPorts) : rr_q;

        resp_valid_o     = '0;
        acc_resp_ready_o = 1'b0;
        for (int unsigned p = 0; p < NrPorts; p++) begin
            resp_o[p] = acc_resp_i;
        end
        if (!fifo_empty) begin
            resp_valid_o[head_idx] = acc_resp_valid_i;
            acc_resp_ready_o       = resp_ready_i[head_idx];
        end
        pop = acc_resp_valid_i && acc_resp_ready_o;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign outstanding_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            count_q    <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            count_q    <= count_d;
        end
    end

    // Fall-through so a response in the same cycle as its request still finds its port.
    fifo_v3 #(
        .FALL_THROUGH (1'b1),
        .DATA_WIDTH   (IdxW),
        .DEPTH        (MaxOutstanding)
    ) i_port_id_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage),
        .data_i     (grant_idx),
        .push_i     (push),
        .data_o     (head_idx),
        .pop_i      (pop)
    );

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(acc_resp_valid_i && fifo_empty))
                else $error("acc_port_arbiter: accelerator response with no outstanding request");
            assert ({fifo_full, fifo_usage} == count_q)
                else $error("acc_port_arbiter: outstanding counter disagrees with port-ID queue");
        end
    end

endmodule
